// File: rtl/pe_pkg.sv
// Shared definitions for the systolic PE array feeder: element width,
// the FP32 zero bubble pattern and the feeder FSM states.
package pe_pkg;

  localparam int unsigned FPW = 32;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift chain for one feeder lane; every enabled cycle shifts one
// entry (data/valid/last) in at the head, and the final stage drives the lane.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         tail_last
);

  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q,  last_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (en) begin
      data_d[0]  = in_data;
      valid_d[0] = in_valid;
      last_d[0]  = in_last;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
        last_d[k]  = last_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  // High only on the advance that moves a last-tagged valid entry into the output stage.
  assign tail_last = en && valid_d[DEPTH-1] && last_d[DEPTH-1];

endmodule

// File: rtl/pe_skew_feeder.sv
// Skewing feeder for the PE array: lane i is delayed by 1+i advance cycles,
// a tile is followed by N-1 flush bubbles and tile_done marks its exit.
module pe_skew_feeder
  import pe_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned FPW = pe_pkg::FPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*FPW-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             en,
  output logic [N*FPW-1:0] out_d,
  output logic [N-1:0]     out_v,
  output logic             tile_done
);

  localparam int unsigned FCW = (N > 2) ? $clog2(N - 1) : 1;

  state_e           state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             tile_done_q, tile_done_d;
  logic             accept;
  logic [N*FPW-1:0] head_data;
  logic             head_last;
  logic [N-1:0]     tail_last;

  assign s_ready   = en && (state_q != FLUSH);
  assign accept    = s_valid && s_ready;
  assign head_data = accept ? s_data : '0;
  assign head_last = accept && s_last;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (en) begin
      case (state_q)
        IDLE, STREAM: begin
          fcnt_d = '0;
          if (accept) begin
            state_d = s_last ? FLUSH : STREAM;
          end
        end
        FLUSH: begin
          if (fcnt_q == FCW'(N - 2)) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // Only lane N-1 is fed a last tag, so OR-ing every tail is equivalent to watching lane N-1.
  always_comb begin
    tile_done_d = |tail_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign tile_done = tile_done_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH (1 + i),
      .W     (FPW)
    ) u_line (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_data   (head_data[i*FPW +: FPW]),
      .in_valid  (accept),
      .in_last   (head_last && (i == N - 1)),
      .out_data  (out_d[i*FPW +: FPW]),
      .out_valid (out_v[i]),
      .tail_last (tail_last[i])
    );
  end

endmodule
